// File: rtl/execute_stage_mdu_pkg.sv
// Shared types for the RV32IM execute stage: ALU/MDU op encodings, decoded control word,
// MDU FSM states and small op-classification helpers.
package execute_stage_mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [3:0] {
    MDU_NONE, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } mdu_op_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    ALUSrc;
    logic    MemRead;
    logic    MemWrite;
    logic    RegWrite;
    logic    MemtoReg;
    logic    is_branch;
    mdu_op_t mdu_op;
  } control_type;

  function automatic logic op_is_mul(input mdu_op_t op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  // rs1 is treated as signed for these ops
  function automatic logic op_a_signed(input mdu_op_t op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic op_b_signed(input mdu_op_t op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/execute_stage_mdu_mdu.sv
// Iterative multiply/divide unit: magnitude shift-add / restoring shift-subtract over
// XLEN/UNROLL cycles, with sign fix-up applied combinationally in DONE.
module mdu_iter
  import execute_stage_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output mdu_state_t      state
);

  // Handshake: start is sampled only in IDLE; busy is high from the start cycle through the
  // last BUSY cycle; the result is valid while state==DONE, for exactly one cycle.
  localparam int K  = XLEN / UNROLL;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  mdu_state_t      state_n;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] hi, lo, b_q;
  logic [XLEN-1:0] hi_n, lo_n;
  mdu_op_t         op_q;
  logic            neg_res, neg_rem, div_zero;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_neg = op_a_signed(op) & a[XLEN-1];
  assign b_neg = op_b_signed(op) & b[XLEN-1];
  assign a_mag = a_neg ? (~a + XLEN'(1)) : a;
  assign b_mag = b_neg ? (~b + XLEN'(1)) : b;

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = BUSY;
        busy    = 1'b1;
      end
      BUSY: begin
        busy = 1'b1;
        if (count == CW'(K - 1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      busy    = 1'b0;
    end
  end

  // UNROLL iterations per cycle; {hi,lo} is the product or {remainder,quotient} pair
  always_comb begin
    logic [XLEN:0] t;
    hi_n = hi;
    lo_n = lo;
    t    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_is_div(op_q)) begin
        t    = {hi_n, lo_n[XLEN-1]};
        lo_n = {lo_n[XLEN-2:0], 1'b0};
        if (t >= {1'b0, b_q}) begin
          t       = t - {1'b0, b_q};
          lo_n[0] = 1'b1;
        end
        hi_n = t[XLEN-1:0];
      end else begin
        t    = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b_q} : '0);
        lo_n = {t[0], lo_n[XLEN-1:1]};
        hi_n = t[XLEN:1];
      end
    end
  end

  always_comb begin
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod   = neg_res ? (~{hi, lo} + (2*XLEN)'(1)) : {hi, lo};
    // divide-by-zero keeps the all-ones quotient regardless of operand signs
    quo    = (neg_res && !div_zero) ? (~lo + XLEN'(1)) : lo;
    rem    = neg_rem ? (~hi + XLEN'(1)) : hi;
    result = '0;
    case (op_q)
      MUL:                 result = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: result = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           result = quo;
      REM, REMU:           result = rem;
      default:             result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      b_q      <= '0;
      op_q     <= MDU_NONE;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (flush) begin
        count <= '0;
      end else if (state == IDLE && start) begin
        count    <= '0;
        hi       <= '0;
        lo       <= a_mag;
        b_q      <= b_mag;
        op_q     <= op;
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= (b == '0);
      end else if (state == BUSY) begin
        hi    <= hi_n;
        lo    <= lo_n;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_stage_mdu.sv
// RV32IM execute stage: single-cycle ALU, iterative MDU and the EX/MEM register.
// Optional build macro FAST_MUL_EN: multiplies use a one-cycle combinational multiplier.
module execute_stage_mdu
  import execute_stage_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  control_type     control_in,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] immediate_data,
  output logic            stall,
  output logic            out_valid,
  output control_type     control_out,
  output logic            ZeroFlag,
  output logic [XLEN-1:0] alu_data,
  output logic [XLEN-1:0] memory_data
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] operand_b, alu_result, mdu_result, ex_result;
  logic [SW-1:0]   shamt;
  logic            iter_op, mdu_start, mdu_busy, mdu_done;
  mdu_state_t      mdu_state;

  assign operand_b = control_in.ALUSrc ? immediate_data : data2;
  assign shamt     = operand_b[SW-1:0];

  always_comb begin
    alu_result = '0;
    case (control_in.alu_op)
      ALU_ADD:    alu_result = data1 + operand_b;
      ALU_SUB:    alu_result = data1 - operand_b;
      ALU_AND:    alu_result = data1 & operand_b;
      ALU_OR:     alu_result = data1 | operand_b;
      ALU_XOR:    alu_result = data1 ^ operand_b;
      ALU_SLL:    alu_result = data1 << shamt;
      ALU_SRL:    alu_result = data1 >> shamt;
      ALU_SRA:    alu_result = $signed(data1) >>> shamt;
      ALU_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(data1) < $signed(operand_b)};
      ALU_SLTU:   alu_result = {{(XLEN-1){1'b0}}, data1 < operand_b};
      ALU_PASS_B: alu_result = operand_b;
      default:    alu_result = '0;
    endcase
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_result;

  assign iter_op   = op_is_div(control_in.mdu_op);
  assign fast_a    = {{XLEN{op_a_signed(control_in.mdu_op) & data1[XLEN-1]}}, data1};
  assign fast_b    = {{XLEN{op_b_signed(control_in.mdu_op) & data2[XLEN-1]}}, data2};
  assign fast_prod = fast_a * fast_b;
  assign fast_result = (control_in.mdu_op == MUL) ? fast_prod[XLEN-1:0]
                                                  : fast_prod[2*XLEN-1:XLEN];
`else
  assign iter_op   = (control_in.mdu_op != MDU_NONE);
`endif

  assign mdu_start = in_valid & iter_op & ~flush;
  assign mdu_done  = (mdu_state == DONE);
  assign stall     = mdu_busy;

  mdu_iter #(.XLEN(XLEN), .UNROLL(UNROLL)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (mdu_start),
    .op     (control_in.mdu_op),
    .a      (data1),
    .b      (data2),
    .busy   (mdu_busy),
    .result (mdu_result),
    .state  (mdu_state)
  );

  always_comb begin
    ex_result = alu_result;
    if (mdu_done) ex_result = mdu_result;
`ifdef FAST_MUL_EN
    else if (op_is_mul(control_in.mdu_op)) ex_result = fast_result;
`endif
  end

  // While stalled the held instruction must not reach MEM until its result is ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      control_out <= '0;
      alu_data    <= '0;
      memory_data <= '0;
      ZeroFlag    <= 1'b0;
    end else if (flush || stall || !in_valid) begin
      out_valid   <= 1'b0;
      control_out <= '0;
    end else begin
      out_valid   <= 1'b1;
      control_out <= control_in;
      alu_data    <= ex_result;
      memory_data <= data2;
      ZeroFlag    <= (ex_result == '0);
    end
  end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Scoreboard bench for execute_stage_mdu: directed corner cases plus randomized ALU/MDU ops.
module tb_execute_stage_mdu;
  import execute_stage_mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = $bits(control_type) + 2 * XLEN + 1;
  localparam int K    = 32;

  logic            clk, rst, flush, in_valid;
  control_type     control_in, control_out;
  logic [XLEN-1:0] data1, data2, immediate_data, alu_data, memory_data;
  logic            stall, out_valid, ZeroFlag;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  execute_stage_mdu #(.XLEN(XLEN), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .control_in(control_in), .data1(data1), .data2(data2),
    .immediate_data(immediate_data), .stall(stall), .out_valid(out_valid),
    .control_out(control_out), .ZeroFlag(ZeroFlag), .alu_data(alu_data),
    .memory_data(memory_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural RV32IM results from plain arithmetic
  function automatic logic [31:0] model(input control_type c, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] imm);
    logic [31:0] b;
    logic [63:0] p;
    b = c.ALUSrc ? imm : d2;
    case (c.mdu_op)
      MUL: begin p = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2}; return p[31:0]; end
      MULH: begin p = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2}; return p[63:32]; end
      MULHSU: begin p = {{32{d1[31]}}, d1} * {32'h0, d2}; return p[63:32]; end
      MULHU: begin p = {32'h0, d1} * {32'h0, d2}; return p[63:32]; end
      DIV: begin
        if (d2 == 0) return 32'hFFFF_FFFF;
        if (d1 == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(d1) / $signed(d2);
      end
      DIVU: return (d2 == 0) ? 32'hFFFF_FFFF : d1 / d2;
      REM: begin
        if (d2 == 0) return d1;
        if (d1 == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) return 32'h0;
        return $signed(d1) % $signed(d2);
      end
      REMU: return (d2 == 0) ? d1 : d1 % d2;
      default: ;
    endcase
    case (c.alu_op)
      ALU_ADD:  return d1 + b;
      ALU_SUB:  return d1 - b;
      ALU_AND:  return d1 & b;
      ALU_OR:   return d1 | b;
      ALU_XOR:  return d1 ^ b;
      ALU_SLL:  return d1 << b[4:0];
      ALU_SRL:  return d1 >> b[4:0];
      ALU_SRA:  return $signed(d1) >>> b[4:0];
      ALU_SLT:  return ($signed(d1) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (d1 < b) ? 32'd1 : 32'd0;
      ALU_PASS_B: return b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int exp_stalls(input control_type c);
    if (c.mdu_op == MDU_NONE) return 0;
`ifdef FAST_MUL_EN
    if (c.mdu_op inside {MUL, MULH, MULHSU, MULHU}) return 0;
`endif
    return K + 1;
  endfunction

  function automatic control_type mk(input alu_op_t a, input logic src, input mdu_op_t m);
    control_type c;
    c           = '0;
    c.alu_op    = a;
    c.ALUSrc    = src;
    c.mdu_op    = m;
    c.RegWrite  = 1'($urandom_range(0, 1));
    c.MemRead   = 1'($urandom_range(0, 1));
    c.MemWrite  = 1'($urandom_range(0, 1));
    c.MemtoReg  = 1'($urandom_range(0, 1));
    c.is_branch = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Drive one instruction, hold it while stalled, then post the expected EX/MEM contents
  task automatic issue_exp(input control_type c, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [31:0] r);
    int n;
    control_in = c; data1 = d1; data2 = d2; immediate_data = imm; in_valid = 1'b1;
    #1;
    n = 0;
    while (stall && n < 200) begin
      @(posedge clk); #1;
      n++;
      check("bubble_during_stall", 64'(out_valid), 64'd0);
    end
    check("stall_cycles", 64'(n), 64'(exp_stalls(c)));
    exp_q.push_back({c, r, (r == 32'h0), d2});
    @(posedge clk); #1;
  endtask

  task automatic issue(input control_type c, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm);
    issue_exp(c, d1, d2, imm, model(c, d1, d2, imm));
  endtask

  task automatic idle(input int n);
    in_valid   = 1'b0;
    control_in = mk(alu_op_t'($urandom_range(0, 10)), 1'b0, mdu_op_t'($urandom_range(0, 8)));
    data1      = $urandom;
    data2      = $urandom;
    repeat (n) begin
      #1;
      check("idle_no_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid got alu_data=%h expected no output", alu_data);
      end else begin
        e = exp_q.pop_front();
        if ({control_out, alu_data, ZeroFlag, memory_data} !== e) begin
          errors++;
          $display("FAIL result got=%h expected=%h", {control_out, alu_data, ZeroFlag, memory_data}, e);
        end
      end
    end
  end

  initial begin
    int wait_n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    control_in = '0; data1 = '0; data2 = '0; immediate_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_alu_data", 64'(alu_data), 64'd0);
    check("reset_memory_data", 64'(memory_data), 64'd0);
    check("reset_zero", 64'(ZeroFlag), 64'd0);
    check("reset_control", 64'(control_out), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    issue_exp(mk(ALU_ADD, 1'b0, MDU_NONE), 32'd5, 32'd7, 32'd0, 32'd12);
    issue_exp(mk(ALU_SUB, 1'b1, MDU_NONE), 32'd9, 32'h1234, 32'd9, 32'd0);
    issue_exp(mk(ALU_ADD, 1'b0, MULH), 32'hFFFF_FFFE, 32'd3, 32'd0, 32'hFFFF_FFFF);
    issue_exp(mk(ALU_ADD, 1'b0, MUL), 32'hFFFF_FFFE, 32'd3, 32'd0, 32'hFFFF_FFFA);
    issue_exp(mk(ALU_ADD, 1'b0, MULHSU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    issue_exp(mk(ALU_ADD, 1'b0, DIV), 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD);
    issue_exp(mk(ALU_ADD, 1'b0, REM), 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFF);
    issue_exp(mk(ALU_ADD, 1'b0, DIVU), 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF);
    issue_exp(mk(ALU_ADD, 1'b0, REM), 32'd7, 32'd0, 32'd0, 32'd7);
    issue_exp(mk(ALU_ADD, 1'b0, DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    issue_exp(mk(ALU_ADD, 1'b0, REM), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue_exp(mk(ALU_ADD, 1'b0, MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE);
    issue_exp(mk(ALU_ADD, 1'b0, DIVU), 32'd100, 32'd7, 32'd0, 32'd14);
    idle(2);

    // flush while the divider is ten cycles into BUSY
    control_in = mk(ALU_ADD, 1'b0, DIVU); data1 = 32'd1000; data2 = 32'd3; in_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("busy_before_flush", 64'(stall), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_stall_same_cycle", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_bubble", 64'(out_valid), 64'd0);
    issue(mk(ALU_ADD, 1'b0, MDU_NONE), 32'd40, 32'd2, 32'd0);
    issue(mk(ALU_ADD, 1'b0, DIV), 32'hFFFF_FF9C, 32'd7, 32'd0);

    // reset in the middle of a multiply
    control_in = mk(ALU_ADD, 1'b0, MUL); data1 = 32'd123; data2 = 32'd456; in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("midop_rst_out_valid", 64'(out_valid), 64'd0);
    check("midop_rst_alu_data", 64'(alu_data), 64'd0);
    check("midop_rst_memory_data", 64'(memory_data), 64'd0);
    check("midop_rst_control", 64'(control_out), 64'd0);
    check("midop_rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    issue(mk(ALU_XOR, 1'b1, MDU_NONE), 32'hF0F0_F0F0, 32'd5, 32'h0FF0_0FF0);
    issue(mk(ALU_ADD, 1'b0, REMU), 32'd1000, 32'd7, 32'd0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: issue(mk(alu_op_t'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), MDU_NONE),
                 rnd_operand(), rnd_operand(), rnd_operand());
        1: issue(mk(ALU_ADD, 1'b0, mdu_op_t'($urandom_range(1, 8))),
                 rnd_operand(), rnd_operand(), rnd_operand());
        default: idle($urandom_range(1, 3));
      endcase
    end
    idle(2);

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
